// File: rtl/mc_mem_if.sv
// Request/response bundle between the control path and the unified memory controller.
// master = control path issuing fetch/load/store, slave = the controller.
interface mc_mem_if;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        busy;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  busy, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output busy, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mc_mem_ctrl.sv
// Unified instruction/data memory controller with fixed programmable access latency.
// Define MC_MEM_MISALIGN_EN to reject accesses whose byte address is not word aligned.
module mc_mem_ctrl #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic       clk,
   input logic       rst,
   mc_mem_if.slave   bus
);

   localparam int unsigned AW         = $clog2(DEPTH_WORDS);
   localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  waitCnt_q, waitCnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic [AW-1:0] index;
   logic          outOfRange;
   logic          misaligned;
   logic          accessErr;
   logic [31:0]   respData;

   assign index      = addr_q[AW+1:2];
   assign outOfRange = {1'b0, addr_q} >= ADDR_LIMIT;

`ifdef MC_MEM_MISALIGN_EN
   assign misaligned = (addr_q[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   assign accessErr = outOfRange | misaligned;

   // Rejected accesses return zero; writes keep presenting the last read word.
   always_comb begin
      respData = rdata_q;
      if (accessErr) begin
         respData = 32'h0;
      end else if (!we_q) begin
         respData = mem[index];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         waitCnt_q <= 4'd0;
         we_q      <= 1'b0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         rdata_q   <= 32'h0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
      end
   end

   // Requests are only sampled in IDLE, so anything arriving while busy is dropped.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d      = bus.req_we;
               addr_d    = bus.req_addr;
               wdata_d   = bus.req_wdata;
               waitCnt_d = WAIT_LOAD;
               state_d   = (WAIT_CYCLES != 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            waitCnt_d = waitCnt_q - 4'd1;
            if (waitCnt_q <= 4'd1) begin
               state_d = RESP;
            end
         end
         RESP: begin
            rdata_d = respData;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Memory has no reset so its contents survive an aborted access.
   always_ff @(posedge clk) begin
      if (state_q == RESP && we_q && !accessErr) begin
         mem[index] <= wdata_q;
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_err   = (state_q == RESP) & accessErr;
   assign bus.rsp_rdata = (state_q == RESP) ? respData : rdata_q;

endmodule

// File: tb/tb_mc_mem_ctrl.sv
// Scoreboard bench for mc_mem_ctrl: a WAIT_CYCLES=2 instance driven through a response
// queue plus a WAIT_CYCLES=0 instance checked directly for its single-cycle latency.
module tb_mc_mem_ctrl;

   localparam int WAIT = 2;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        we;
   } exp_t;

   logic clk;
   logic rst;

   mc_mem_if bus();
   mc_mem_if bus0();

   exp_t        sb[$];
   exp_t        monExp;
   bit [31:0]   modelMem [1024];
   logic [31:0] lastRead;
   bit          lastReadKnown;
   int          checkCount;
   int          errorCount;

   mc_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   mc_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dutNoWait (
      .clk (clk),
      .rst (rst),
      .bus (bus0.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checkCount, errorCount);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Every response is matched against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus.rsp_valid === 1'b1) begin
         checkOutput("sbPending", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            monExp = sb.pop_front();
            checkOutput("rspErr", 32'(bus.rsp_err), 32'(monExp.err));
            if (!monExp.we) begin
               checkOutput("rspRdata", bus.rsp_rdata, monExp.rdata);
               lastRead      = monExp.rdata;
               lastReadKnown = 1'b1;
            end else if (!monExp.err) begin
               if (lastReadKnown) checkOutput("rdataHold", bus.rsp_rdata, lastRead);
            end else begin
               lastReadKnown = 1'b0;
            end
         end
      end
   end

   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input bit extraReq);
      exp_t     e;
      int       cycles;
      int       busyCycles;
      bit       got;
      bit       err;
      bit [9:0] idx;
      cycles     = 0;
      busyCycles = 0;
      got        = 1'b0;
      @(negedge clk);
      checkOutput("busyIdle", 32'(bus.busy), 32'd0);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      @(posedge clk);
      idx = addr[11:2];
      err = (addr >= 32'h1000);
`ifdef MC_MEM_MISALIGN_EN
      if (addr[1:0] != 2'b00) err = 1'b1;
`endif
      e.we    = we;
      e.err   = err;
      e.rdata = 32'h0;
      if (!we && !err) e.rdata = modelMem[idx];
      if (we && !err) modelMem[idx] = wdata;
      sb.push_back(e);
      #1;
      bus.req_valid = 1'b0;
      while (!got && cycles < 20) begin
         @(negedge clk);
         cycles++;
         if (bus.busy === 1'b1) busyCycles++;
         if (bus.rsp_valid === 1'b1) got = 1'b1;
         if (extraReq && cycles == 1) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_addr  = 32'h20;
            bus.req_wdata = 32'hBAD0BAD0;
         end else begin
            bus.req_valid = 1'b0;
         end
      end
      checkOutput("rspSeen", 32'(got), 32'd1);
      checkOutput("latency", 32'(cycles), 32'(WAIT + 1));
      checkOutput("busyCycles", 32'(busyCycles), 32'(WAIT + 1));
      @(negedge clk);
      checkOutput("busyDone", 32'(bus.busy), 32'd0);
   endtask

   task automatic applyStimulusNoWait(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [31:0] expRdata);
      int cycles;
      int busyCycles;
      bit got;
      cycles     = 0;
      busyCycles = 0;
      got        = 1'b0;
      @(negedge clk);
      bus0.req_valid = 1'b1;
      bus0.req_we    = we;
      bus0.req_addr  = addr;
      bus0.req_wdata = wdata;
      @(posedge clk);
      #1;
      bus0.req_valid = 1'b0;
      while (!got && cycles < 10) begin
         @(negedge clk);
         cycles++;
         if (bus0.busy === 1'b1) busyCycles++;
         if (bus0.rsp_valid === 1'b1) begin
            got = 1'b1;
            checkOutput("nw.rspErr", 32'(bus0.rsp_err), 32'd0);
            if (!we) checkOutput("nw.rspRdata", bus0.rsp_rdata, expRdata);
         end
      end
      checkOutput("nw.rspSeen", 32'(got), 32'd1);
      checkOutput("nw.latency", 32'(cycles), 32'd1);
      checkOutput("nw.busyCycles", 32'(busyCycles), 32'd1);
      @(negedge clk);
      checkOutput("nw.busyDone", 32'(bus0.busy), 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      checkCount     = 0;
      errorCount     = 0;
      lastRead       = 32'h0;
      lastReadKnown  = 1'b1;
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus0.req_valid = 1'b0;
      bus0.req_we    = 1'b0;
      bus0.req_addr  = 32'h0;
      bus0.req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      checkOutput("rst.busy", 32'(bus.busy), 32'd0);
      checkOutput("rst.rspValid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("rst.rspRdata", bus.rsp_rdata, 32'h0);
      checkOutput("rst.rspErr", 32'(bus.rsp_err), 32'd0);
      checkOutput("rst.nwBusy", 32'(bus0.busy), 32'd0);
      rst = 1'b0;

      applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      applyStimulus(1'b0, 32'h10, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'h4, 32'h11112222, 1'b0);
      applyStimulus(1'b0, 32'h4, 32'h0, 1'b0);

      // A write pulse to 0x20 lands while the read of 0x10 is still in flight.
      applyStimulus(1'b0, 32'h10, 32'h0, 1'b1);

      applyStimulus(1'b1, 32'h0, 32'hA5A50000, 1'b0);
      applyStimulus(1'b0, 32'h1000, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'h1000, 32'h5, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);

      applyStimulus(1'b1, 32'h8, 32'hCAFEF00D, 1'b0);
      applyStimulus(1'b0, 32'h8, 32'h0, 1'b0);

      // Abort a write to 0x8 while it is waiting; the old word must survive.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h8;
      bus.req_wdata = 32'h12345678;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      checkOutput("abort.busyBefore", 32'(bus.busy), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("abort.busy", 32'(bus.busy), 32'd0);
      checkOutput("abort.rspValid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("abort.rspRdata", bus.rsp_rdata, 32'h0);
      checkOutput("abort.rspErr", 32'(bus.rsp_err), 32'd0);
      lastRead      = 32'h0;
      lastReadKnown = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      applyStimulus(1'b0, 32'h8, 32'h0, 1'b0);

      applyStimulus(1'b0, 32'h6, 32'h0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         a = 32'($urandom_range(0, 1023)) << 2;
         d = $urandom;
         applyStimulus(1'b1, a, d, 1'b0);
         applyStimulus(1'b0, a, 32'h0, 1'b0);
      end

      applyStimulusNoWait(1'b1, 32'h0, 32'h00000077, 32'h0);
      applyStimulusNoWait(1'b0, 32'h0, 32'h0, 32'h00000077);

      repeat (4) @(negedge clk);
      checkOutput("sbEmpty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/mc_mem_ctrl.md
MC_MEM_CTRL -- requirements
Module: mc_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the unified instruction/data memory; power of two.
REQ-002 Parameter WAIT_CYCLES, default 2, added access latency in cycles; legal range 0..15.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  access request from control path (fetch or load/store).
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  32  byte address; PC or ALU register as selected upstream.
REQ-008 req_wdata  input  32  store data.
REQ-009 busy  output  1  controller is not in IDLE; the FSM holds its state while high.
REQ-010 rsp_valid  output  1  one-cycle pulse; access complete.
REQ-011 rsp_rdata  output  32  read data; feeds IR on fetch and data register on load.
REQ-012 rsp_err  output  1  qualified by rsp_valid; access rejected.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-014 In IDLE with req_valid=1, the block SHALL latch req_we, req_addr and req_wdata, load wait_cnt=WAIT_CYCLES and set busy=1 next cycle.
- Next state: WAIT if WAIT_CYCLES>0, otherwise RESP.
REQ-015 In WAIT, wait_cnt SHALL decrement each cycle; the state SHALL move to RESP on the cycle wait_cnt reaches 1.
REQ-016 In RESP:
- rsp_valid SHALL be 1 for exactly one cycle.
- A valid write SHALL update mem[index] at the end of that cycle.
- A valid read SHALL drive rsp_rdata=mem[index].
- Next state SHALL be IDLE.
REQ-017 Latency SHALL be WAIT_CYCLES+1 cycles from the accept edge to rsp_valid; minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-018 index SHALL be latched_addr[log2(DEPTH_WORDS)+1:2].
REQ-019 Out-of-range access (latched_addr >= 4*DEPTH_WORDS) SHALL give rsp_err=1 with rsp_valid, no write, and rsp_rdata=0.
REQ-020 req_valid SHALL be ignored while busy=1: no queuing, no corruption of latched fields.
REQ-021 rsp_rdata SHALL hold its last value until the next read response; write responses SHALL leave it unchanged.
REQ-022 Read-after-write to the same address on the next request SHALL return the newly written data.
REQ-023 Unknown state encodings SHALL return to IDLE.

Reset
REQ-024 On rst, the block SHALL immediately set:
- state=IDLE, busy=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, wait_cnt=0, latched fields=0.
REQ-025 Reset mid-operation SHALL abort the access with no memory write; memory contents SHALL NOT be cleared by reset.

Configuration
REQ-026 Macro MC_MEM_MISALIGN_EN defined: latched_addr[1:0]!=0 SHALL produce rsp_err=1 with rsp_valid and no write; rsp_rdata=0.
REQ-027 Macro MC_MEM_MISALIGN_EN undefined: addr[1:0] SHALL be ignored and the access performed on the aligned word.

Verification (WAIT_CYCLES=2, DEPTH_WORDS=1024)
REQ-028 Write 0xDEADBEEF to 0x10, then read 0x10 -> rsp_valid 3 cycles after each accept, read returns 0xDEADBEEF, rsp_err=0.
REQ-029 Second req_valid pulse to 0x20 one cycle after accepting a read of 0x10 -> ignored; only the 0x10 response is produced; busy stays high 3 cycles.
REQ-030 Read of 0x1000 (out of range) -> rsp_valid with rsp_err=1, rsp_rdata=0; write of 0x5 to 0x1000 -> rsp_err=1, mem[0] unchanged.
REQ-031 rst asserted in WAIT during a write of 0x12345678 to 0x8 -> outputs zero immediately, no rsp_valid; later read of 0x8 returns the prior value.
REQ-032 Read of 0x6, with MC_MEM_MISALIGN_EN:
- defined -> rsp_err=1.
- undefined -> returns mem[1], rsp_err=0.
REQ-033 WAIT_CYCLES=0 build: read of 0x0 -> rsp_valid 1 cycle after accept, busy high exactly 1 cycle.
